// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and scan-code constants for the keyboard and display stages.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_SPACE = 8'h29;

  function automatic logic odd_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser plus FILTER-sample debounce of a raw PS/2 clock line.
// Emits a single-cycle pulse on the cycle the filtered level flips 1->0.
module ps2_filter #(
  parameter int FILTER = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_fall
);
  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic          r_s1, r_s2, r_level;
  logic [FW-1:0] r_cnt;
  logic          w_done;

  // Flip on the FILTER-th consecutive sample that disagrees with the level.
  assign w_done = (r_s2 != r_level) && (r_cnt == FW'(FILTER - 1));
  assign o_fall = w_done && r_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames into a two-byte scan-code history.
// Define PS2_PARITY_CHECK_EN to enforce odd parity; otherwise the parity bit is ignored.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key,
  output logic        key_valid,
  output logic        frame_err
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
`ifdef PS2_PARITY_CHECK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  ps2_state_e    r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_idle;
  logic [15:0]   r_key;
  logic          r_key_valid, r_frame_err;
  logic          r_data_s1, r_data_s2;
  logic          w_fall, w_good;

  ps2_filter #(.FILTER(FILTER)) u_clk_filt (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (ps2_clk),
    .o_fall (w_fall)
  );

  // Data shares the clock's synchroniser depth, so it is aligned with w_fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
    end else begin
      r_data_s1 <= ps2_data;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_good = r_data_s2 & (~PAR_EN | odd_ok(r_shift, r_parity));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_idle      <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_idle <= '0;
        case (r_state)
          IDLE: if (!r_data_s2) begin
            r_state  <= DATA;
            r_bitcnt <= '0;
          end
          DATA: begin
            r_shift  <= {r_data_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= r_data_s2;
            r_state  <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (w_good) begin
              r_key       <= {r_key[7:0], r_shift};
              r_key_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        // A fall always wins over an expiring timeout (handled above).
        if (r_idle == TW'(TIMEOUT - 1)) begin
          r_state     <= IDLE;
          r_idle      <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end else begin
        r_idle <= '0;
      end
    end
  end

  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx with a scoreboard of expected key_valid/frame_err events.
module tb_ps2_key_rx;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 40;

  typedef struct packed {
    logic        err;
    logic [15:0] key;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] key;
  logic        key_valid, frame_err;

  exp_t        sb[$];
  logic [15:0] exp_key = 16'h0000;
  int          n_assert = 0;
  int          n_fail = 0;

  ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (key),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t ev;
    if (!reset && (key_valid || frame_err)) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_pulse: observed kv=%b fe=%b key=%h expected none", key_valid, frame_err, key);
      end
      if (sb.size() != 0) begin
        ev = sb.pop_front();
        n_assert++;
        assert ({frame_err, key_valid, key} === {ev.err, ~ev.err, ev.key}) else begin
          n_fail++;
          $error("FAIL pulse: observed fe=%b kv=%b key=%h expected fe=%b kv=%b key=%h",
                 frame_err, key_valid, key, ev.err, ~ev.err, ev.key);
        end
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic par_flip, input logic stop_v,
                           input int nbits, input logic glitch);
    logic [10:0] f;
    f = {stop_v, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glitch) begin
        wait_n(15);
        ps2_clk = 1'b0;
        wait_n(3);
        ps2_clk = 1'b1;
        wait_n(HALF - 18);
      end else begin
        wait_n(HALF);
      end
      ps2_clk = 1'b0;
      wait_n(HALF);
      ps2_clk = 1'b1;
    end
    wait_n(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic good_frame(input string tag, input logic [7:0] b, input logic glitch);
    exp_key = {exp_key[7:0], b};
    sb.push_back({1'b0, exp_key});
    send_bits(b, 1'b0, 1'b1, 11, glitch);
    wait_n(50);
    chk(tag, {16'h0, key}, {16'h0, exp_key});
  endtask

  task automatic bad_frame(input string tag, input logic [7:0] b, input logic par_flip,
                           input logic stop_v);
    sb.push_back({1'b1, exp_key});
    send_bits(b, par_flip, stop_v, 11, 1'b0);
    wait_n(50);
    chk(tag, {16'h0, key}, {16'h0, exp_key});
  endtask

  initial begin
    wait_n(5);
    reset = 1'b0;
    wait_n(5);
    chk("reset_key", {16'h0, key}, 32'h0);
    chk("reset_kv", {31'h0, key_valid}, 32'h0);
    chk("reset_fe", {31'h0, frame_err}, 32'h0);
    wait_n(100);

    good_frame("single_2B", 8'h2B, 1'b0);
    chk("single_2B_exact", {16'h0, key}, 32'h0000_002B);
    wait_n(100);

    good_frame("break_F0", 8'hF0, 1'b0);
    wait_n(100);
    good_frame("break_29", 8'h29, 1'b0);
    chk("break_F029_exact", {16'h0, key}, 32'h0000_F029);
    wait_n(100);

`ifdef PS2_PARITY_CHECK_EN
    bad_frame("bad_parity", 8'h2B, 1'b1, 1'b1);
`else
    exp_key = {exp_key[7:0], 8'h2B};
    sb.push_back({1'b0, exp_key});
    send_bits(8'h2B, 1'b1, 1'b1, 11, 1'b0);
    wait_n(50);
    chk("parity_ignored", {16'h0, key}, 32'h0000_292B);
`endif
    wait_n(100);

    bad_frame("bad_stop", 8'h55, 1'b0, 1'b0);
    wait_n(100);

    // Start bit plus four data bits, then let the line sit idle past the timeout.
    sb.push_back({1'b1, exp_key});
    send_bits(8'hA5, 1'b0, 1'b1, 5, 1'b0);
    wait_n(TIMEOUT + 100);
    chk("timeout_key", {16'h0, key}, {16'h0, exp_key});
    chk("timeout_drained", sb.size(), 0);
    good_frame("after_timeout_1C", 8'h1C, 1'b0);
    chk("after_timeout_low", {24'h0, key[7:0]}, 32'h1C);
    wait_n(100);

    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      wait_n(3);
      ps2_clk = 1'b1;
      wait_n(30);
    end
    chk("glitch_idle_nopulse", sb.size(), 0);
    good_frame("glitch_2B", 8'h2B, 1'b1);
    chk("glitch_2B_low", {24'h0, key[7:0]}, 32'h2B);
    wait_n(100);

    send_bits(8'h29, 1'b0, 1'b1, 5, 1'b0);
    reset = 1'b1;
    wait_n(3);
    chk("midreset_key", {16'h0, key}, 32'h0);
    reset = 1'b0;
    exp_key = 16'h0000;
    wait_n(100);
    chk("midreset_key_hold", {16'h0, key}, 32'h0);
    good_frame("post_reset_29", 8'h29, 1'b0);
    chk("post_reset_exact", {16'h0, key}, 32'h0000_0029);

    wait_n(300);
    chk("hold_key", {16'h0, key}, 32'h0000_0029);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
